// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-at-a-time matrix keypad scanner with whole-scan debounce.
// Key auto-repeat is built only when the macro KEYPAD_REPEAT_EN is defined.
//
// state     | meaning
// ST_DRIVE  | wait for a tick, then pull the current row low
// ST_SETTLE | count SETTLE ticks while the row and column lines settle
// ST_SAMPLE | on a tick, fold this row's pressed columns into the scan result
// ST_EVAL   | one clk: debounce the full-scan result, commit, restart at row 0
module keypad_scan_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SETTLE       = 16,
  parameter int STABLE_SCANS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  localparam int KW = ($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clock_enable,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi_key
);
  localparam int RW  = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = ($clog2(SETTLE) > 1) ? $clog2(SETTLE) : 1;
  localparam int STW = $clog2(STABLE_SCANS + 1);

  if (ROWS < 2 || COLS < 2 || SETTLE < 1 || STABLE_SCANS < 2 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: illegal parameter values");
  end

  typedef enum logic [1:0] {ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_EVAL} state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [1:0]      hits_q, hits_d;
  logic [KW-1:0]   low_q, low_d;
  logic [KW:0]     cand_q, cand_d;
  logic [STW-1:0]  stab_q, stab_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            multi_q, multi_d;

  logic [COLS-1:0] pressed;
  int              row_hits, row_low, hit_sum;
  logic [KW:0]     cand;
  logic [STW-1:0]  stab_next;
  logic            commit_press, commit_release, rep_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_DRIVE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRIVE:  if (clock_enable) state_d = ST_SETTLE;
      ST_SETTLE: if (clock_enable && settle_q == SW'(SETTLE - 1)) state_d = ST_SAMPLE;
      ST_SAMPLE: if (clock_enable) state_d = (row_q == RW'(ROWS - 1)) ? ST_EVAL : ST_DRIVE;
      ST_EVAL:   state_d = ST_DRIVE;
      default:   state_d = ST_DRIVE;
    endcase
  end

  // Scan decode: rows are visited in ascending order, so the first row with a hit holds the lowest index.
  always_comb begin
    pressed  = ~col_s2_q;
    row_hits = 0;
    row_low  = 0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pressed[c]) begin
        row_hits = row_hits + 1;
        row_low  = c;
      end
    end
    hit_sum = int'(hits_q) + row_hits;
    cand    = {hits_q != 2'd0, low_q};
    if (cand == cand_q)
      stab_next = (stab_q == STW'(STABLE_SCANS)) ? stab_q : stab_q + STW'(1);
    else
      stab_next = STW'(1);
    commit_press   = (stab_next == STW'(STABLE_SCANS)) && cand[KW] &&
                     (!key_held_q || key_code_q != low_q);
    commit_release = (stab_next == STW'(STABLE_SCANS)) && !cand[KW] && key_held_q;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);

  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_armed_q, rep_armed_d;

  // rep_armed_q marks that the first (delayed) repeat has already fired.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (state_q == ST_EVAL) begin
      if (commit_press || commit_release || !key_held_q) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end else if (int'(rep_cnt_q) + 1 == (rep_armed_q ? REPEAT_RATE : REPEAT_DELAY)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RPW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    col_s1_d    = col_in;
    col_s2_d    = col_s1_q;
    row_d       = row_q;
    settle_d    = settle_q;
    row_out_d   = row_out_q;
    hits_d      = hits_q;
    low_d       = low_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_d     = multi_q;
    case (state_q)
      ST_DRIVE: if (clock_enable) begin
        row_out_d = ~(ROWS'(1) << row_q);
        settle_d  = '0;
      end
      ST_SETTLE: if (clock_enable) settle_d = settle_q + SW'(1);
      ST_SAMPLE: if (clock_enable) begin
        hits_d = (hit_sum >= 2) ? 2'd2 : 2'(hit_sum);
        if (hits_q == 2'd0 && row_hits != 0) low_d = KW'(int'(row_q) * COLS + row_low);
        if (row_q == RW'(ROWS - 1)) row_out_d = '1;
        else                        row_d     = row_q + RW'(1);
      end
      ST_EVAL: begin
        cand_d      = cand;
        stab_d      = stab_next;
        multi_d     = (hits_q >= 2'd2);
        hits_d      = '0;
        low_d       = '0;
        row_d       = '0;
        key_valid_d = commit_press | rep_fire;
        if (commit_press) begin
          key_code_d = low_q;
          key_held_d = 1'b1;
        end
        if (commit_release) key_held_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q    <= '1;
      col_s2_q    <= '1;
      row_q       <= '0;
      settle_q    <= '0;
      row_out_q   <= '1;
      hits_q      <= '0;
      low_q       <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      row_q       <= row_d;
      settle_q    <= settle_d;
      row_out_q   <= row_out_d;
      hits_q      <= hits_d;
      low_q       <= low_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: 4x4 matrix model, table of whole-scan vectors,
// plus hand sequences for mid-scan reset, clock_enable freeze and (with KEYPAD_REPEAT_EN) auto-repeat.
module tb_keypad_scan_ctrl;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SETTLE   = 2;
  localparam int SCAN_CYC = ROWS * (SETTLE + 2) + 1;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clock_enable;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
  logic [15:0] keys;

  int         n_vec = 0;
  int         n_bad = 0;
  int         pulses = 0;
  int         onehot_bad = 0;
  int         p0;
  logic [3:0] last_code = '0;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .STABLE_SCANS(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .clock_enable(clock_enable), .col_in(col_in),
    .row_out(row_out), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_out[r] && keys[r*COLS + c]) col_in[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      pulses++;
      last_code = key_code;
    end
    if (!$onehot0(~row_out)) onehot_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_scans(input int n);
    repeat (SCAN_CYC * n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    int          code;
    int          held;
    int          multi;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{16'h0000, 2, 0,  0, 0, 0};
    vecs[1]  = '{16'h0200, 1, 0,  0, 0, 0};
    vecs[2]  = '{16'h0000, 3, 0,  0, 0, 0};
    vecs[3]  = '{16'h0200, 2, 0,  0, 0, 0};
    vecs[4]  = '{16'h0200, 1, 1,  9, 1, 0};
    vecs[5]  = '{16'h0200, 1, 0,  9, 1, 0};
    vecs[6]  = '{16'h0000, 2, 0,  9, 1, 0};
    vecs[7]  = '{16'h0000, 1, 0,  9, 0, 0};
    vecs[8]  = '{16'h0420, 1, 0,  9, 0, 1};
    vecs[9]  = '{16'h0420, 2, 1,  5, 1, 1};
    vecs[10] = '{16'h0400, 3, 1, 10, 1, 0};
    vecs[11] = '{16'h8000, 3, 1, 15, 1, 0};
    vecs[12] = '{16'h0001, 3, 1,  0, 1, 0};
    vecs[13] = '{16'h8001, 1, 0,  0, 1, 1};
    vecs[14] = '{16'h0000, 3, 0,  0, 0, 0};
    vecs[15] = '{16'h0040, 3, 1,  6, 1, 0};
    vecs[16] = '{16'h0000, 3, 0,  6, 0, 0};

    rst = 1'b1;
    clock_enable = 1'b1;
    keys = '0;
    repeat (3) @(negedge clk);
    check("reset row_out", row_out, 4'hF);
    check("reset key_code", key_code, 0);
    check("reset key_valid", key_valid, 0);
    check("reset key_held", key_held, 0);
    check("reset multi_key", multi_key, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      keys = vecs[i].keys;
      p0 = pulses;
      run_scans(vecs[i].scans);
      check($sformatf("v%0d pulses", i), pulses - p0, vecs[i].pulses);
      check($sformatf("v%0d key_code", i), key_code, vecs[i].code);
      check($sformatf("v%0d key_held", i), key_held, vecs[i].held);
      check($sformatf("v%0d multi_key", i), multi_key, vecs[i].multi);
      if (vecs[i].pulses > 0) check($sformatf("v%0d pulse code", i), last_code, vecs[i].code);
    end

    // Reset in the middle of row 2 settling, with key 9 committed.
    keys = 16'h0200;
    p0 = pulses;
    run_scans(3);
    check("pre-reset commit pulses", pulses - p0, 1);
    check("pre-reset key_held", key_held, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("row 2 settling row_out", row_out, 4'hB);
    rst = 1'b1;
    #1;
    check("async reset row_out", row_out, 4'hF);
    check("async reset key_code", key_code, 0);
    check("async reset key_held", key_held, 0);
    check("async reset key_valid", key_valid, 0);
    check("async reset multi_key", multi_key, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first tick after reset row_out", row_out, 4'hE);
    p0 = pulses;
    repeat (2 * SCAN_CYC - 1) @(posedge clk);
    @(negedge clk);
    check("history cleared held", key_held, 0);
    check("history cleared pulses", pulses - p0, 0);
    run_scans(1);
    check("recommit pulses", pulses - p0, 1);
    check("recommit key_code", key_code, 9);

    // Freeze mid-scan with clock_enable low; key 3 replaces key 9.
    keys = 16'h0008;
    p0 = pulses;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre-freeze row_out", row_out, 4'hD);
    clock_enable = 1'b0;
    repeat (200) @(negedge clk);
    check("frozen row_out", row_out, 4'hD);
    check("frozen pulses", pulses - p0, 0);
    check("frozen key_held", key_held, 1);
    check("frozen key_code", key_code, 9);
    clock_enable = 1'b1;
    repeat (SCAN_CYC - 6) @(posedge clk);
    @(negedge clk);
    run_scans(1);
    check("resume 2 scans key_code", key_code, 9);
    check("resume 2 scans pulses", pulses - p0, 0);
    run_scans(1);
    check("key 3 commit pulses", pulses - p0, 1);
    check("key 3 commit key_code", key_code, 3);

    // Keep key 3 down: repeats only in the KEYPAD_REPEAT_EN build (commit +4, +6 scans).
    p0 = pulses;
    run_scans(3);
    check("hold +3 scans pulses", pulses - p0, 0);
    run_scans(1);
    check("hold +4 scans pulses", pulses - p0, REP);
    run_scans(1);
    check("hold +5 scans pulses", pulses - p0, REP);
    run_scans(1);
    check("hold +6 scans pulses", pulses - p0, 2 * REP);
    check("hold key_code", key_code, 3);
    check("hold last pulse code", last_code, 3);

    check("row_out one-low violations", onehot_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Matrix keypad scan controller. Drives keypad rows one at a time and samples the column lines, then debounces the scan result across whole scans. Emits one key code with a single-cycle valid strobe per debounced press. Sits between the raw keypad pins and user logic, and shares the tick-strobe (clock_enable) timing scheme with the single-button debouncer path.

Parameters:
ROWS, 4, number of row lines driven (>=2)
COLS, 4, number of column lines sampled (>=2)
SETTLE, 16, clock_enable ticks to wait after a row switch before sampling (>=1)
STABLE_SCANS, 4, consecutive identical full-scan results required to commit (>=2)
REPEAT_DELAY, 32, full scans from press commit to first repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 8, full scans between subsequent repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clock_enable  in  1  tick strobe; all scan timing advances only on cycles where it is high
col_in  in  COLS  raw asynchronous columns; active-low (pulled up, pressed = 0)
row_out  out  ROWS  row drive; active-low, at most one bit low at any time
key_code  out  KW = max(1, $clog2(ROWS*COLS))  committed key index = row*COLS + col
key_valid  out  1  one-clk pulse on each press commit
key_held  out  1  level; high while a committed key is down
multi_key  out  1  high when the last full scan saw more than one pressed key

Behaviour:
- col_in passes through a 2-flop synchronizer per bit before any use.
- Reset (async assert, sync release): row_out = all ones, key_code = 0, key_valid = 0, key_held = 0, multi_key = 0. All counters and the scan accumulator clear. FSM = DRIVE, row index = 0.
- FSM states: DRIVE, SETTLE, SAMPLE, EVAL.
  - DRIVE: on a tick, pull row_out[row] low and go to SETTLE. Settle count = 0.
  - SETTLE: each tick increments the count. On a tick with count == SETTLE-1, go to SAMPLE.
  - SAMPLE: on a tick, capture the inverted synchronized columns into the accumulator. Update: pressed count, saturating at 2; lowest pressed index in row-major order.
    - If row < ROWS-1: row++, go to DRIVE. The new row is driven on the next tick, not in the same cycle.
    - Else: release all rows and go to EVAL.
  - EVAL: one clk, no tick required. Candidate = {any_pressed, lowest_index}.
    - If the candidate equals the previous scan's candidate: stable count++ (saturates at STABLE_SCANS). Otherwise the stable count loads 1.
    - multi_key <= (pressed count >= 2).
    - Clear the accumulator, row = 0, go to DRIVE.
- Per-row cost: SETTLE+2 ticks. Full scan: ROWS*(SETTLE+2) ticks + 1 clk.
- Commit happens in EVAL when the stable count reaches STABLE_SCANS and the candidate differs from the committed state.
  - Press (none -> key, or key A -> key B): key_code <= index, key_held <= 1, key_valid = 1 for the next clk only.
  - Release (key -> none): key_held <= 0, key_code holds its last value, no pulse.
- Multiple keys pressed: the lowest index is the candidate. multi_key is informational only and does not block a commit.
- clock_enable low: FSM, counters and row_out freeze. An EVAL already entered still completes.
- rst asserted mid-scan discards the partial scan and the debounce history.

Optional Feature:
Macro KEYPAD_REPEAT_EN.
- Defined: while key_held, a scan counter runs. key_valid re-pulses with the same key_code REPEAT_DELAY full scans after the commit, then every REPEAT_RATE scans. The counter clears on any commit or release.
- Undefined: exactly one key_valid pulse per press. The repeat logic and parameters are unused and synthesize away.

Test Plan:
Common setup for all scenarios: ROWS=COLS=4, SETTLE=2, STABLE_SCANS=3, clock_enable=1 every cycle (full scan = 16 ticks + 1 clk).
1. Assert rst mid-SETTLE of row 2 -> row_out=4'hF and all outputs 0 immediately. After release, row_out=4'hE on the first tick.
2. Hold col_in[1]=0 whenever row_out[2]=0 (key 9) -> exactly one key_valid pulse with key_code=9 at the 3rd matching EVAL. key_held=1 thereafter.
3. Press key 9 for exactly one scan, then release -> no key_valid, key_held stays 0.
4. After scenario 2, release -> key_held falls at the 3rd empty EVAL, key_code stays 9, no pulse.
5. Hold keys 5 and 10 together -> multi_key=1 after the first scan, one pulse with key_code=5.
6. Hold key 3 with clock_enable low for 200 cycles -> row_out and state unchanged. With KEYPAD_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2: pulses at commit, then at +4 and +6 scans.
